// File: rtl/store_pkg.sv
// Shared constants for the even/odd parity bank store.
// Default sizes, derived widths and err bit positions.
package store_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 4;
    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF = $clog2(DEPTH_DEF + 1);

    localparam int ERR_W        = 3;
    localparam int ERR_OVF_L    = 0;
    localparam int ERR_OVF_R    = 1;
    localparam int ERR_CONFLICT = 2;

endpackage

// File: rtl/bank_fifo.sv
// Single first-word-fall-through FIFO bank with overflow pulse.
// Ports: clk, reset (async low), push/din, pop, dout/valid/full/count, ovf.
// STORE_OVERWRITE_EN: push to a full bank replaces the oldest word.
module bank_fifo
    import store_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               din,
    input  logic                           pop,
    output logic [WIDTH-1:0]               dout,
    output logic                           valid,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;
    logic             adv_rd;

    assign valid  = (count != '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop & valid;
    // A pop on a full bank frees a slot, so only push-without-pop overflows.
    assign ovf    = push & full & ~do_pop;

`ifdef STORE_OVERWRITE_EN
    assign do_push = push;
    assign adv_rd  = do_pop | ovf;
`else
    assign do_push = push & ~ovf;
    assign adv_rd  = do_pop;
`endif

    assign dout = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (adv_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !adv_rd) begin
                count <= count + CW'(1);
            end else if (adv_rd && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/parity_bank_store.sv
// Routes even words to the left bank and odd words to the right bank.
// Ports: clk, reset (async low), Din, en_left/en_right, rd_left/rd_right,
//   dout_x, valid_x, full_x, count_x, err {conflict, ovf_right, ovf_left},
//   clr_err. Macro STORE_OVERWRITE_EN selects overwrite on full.
module parity_bank_store
    import store_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           Din,
    input  logic                       en_left,
    input  logic                       en_right,
    input  logic                       rd_left,
    input  logic                       rd_right,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           dout_left,
    output logic [WIDTH-1:0]           dout_right,
    output logic                       valid_left,
    output logic                       valid_right,
    output logic                       full_left,
    output logic                       full_right,
    output logic [$clog2(DEPTH+1)-1:0] count_left,
    output logic [$clog2(DEPTH+1)-1:0] count_right,
    output logic [ERR_W-1:0]           err
);

    logic             en_left_q;
    logic             en_right_q;
    logic [WIDTH-1:0] din_q;
    logic             din_chg;
    logic             conflict;
    logic             wr_left;
    logic             wr_right;
    logic             ovf_left;
    logic             ovf_right;
    logic [ERR_W-1:0] err_set;

    // A held enable only writes again when the data word changes.
    assign din_chg  = (Din != din_q);
    assign conflict = en_left & en_right;
    assign wr_left  = en_left & ~conflict & (~en_left_q | din_chg);
    assign wr_right = en_right & ~conflict & (~en_right_q | din_chg);

    always_comb begin
        err_set               = '0;
        err_set[ERR_OVF_L]    = ovf_left;
        err_set[ERR_OVF_R]    = ovf_right;
        err_set[ERR_CONFLICT] = conflict;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_left_q  <= 1'b0;
            en_right_q <= 1'b0;
            din_q      <= '0;
            err        <= '0;
        end else begin
            en_left_q  <= en_left;
            en_right_q <= en_right;
            din_q      <= Din;
            // New errors in the clearing cycle survive the clear.
            err        <= clr_err ? err_set : (err | err_set);
        end
    end

    bank_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_left (
        .clk   (clk),
        .reset (reset),
        .push  (wr_left),
        .din   (Din),
        .pop   (rd_left),
        .dout  (dout_left),
        .valid (valid_left),
        .full  (full_left),
        .count (count_left),
        .ovf   (ovf_left)
    );

    bank_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_right (
        .clk   (clk),
        .reset (reset),
        .push  (wr_right),
        .din   (Din),
        .pop   (rd_right),
        .dout  (dout_right),
        .valid (valid_right),
        .full  (full_right),
        .count (count_right),
        .ovf   (ovf_right)
    );

endmodule

// File: tb/tb_parity_bank_store.sv
// Directed and randomized check of parity_bank_store against a queue model.
// Model follows STORE_OVERWRITE_EN the same way the design does.
module tb_parity_bank_store;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] Din = '0;
    logic         en_left = 1'b0;
    logic         en_right = 1'b0;
    logic         rd_left = 1'b0;
    logic         rd_right = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] dout_left;
    logic [W-1:0] dout_right;
    logic         valid_left;
    logic         valid_right;
    logic         full_left;
    logic         full_right;
    logic [2:0]   count_left;
    logic [2:0]   count_right;
    logic [2:0]   err;

    parity_bank_store #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Din         (Din),
        .en_left     (en_left),
        .en_right    (en_right),
        .rd_left     (rd_left),
        .rd_right    (rd_right),
        .clr_err     (clr_err),
        .dout_left   (dout_left),
        .dout_right  (dout_right),
        .valid_left  (valid_left),
        .valid_right (valid_right),
        .full_left   (full_left),
        .full_right  (full_right),
        .count_left  (count_left),
        .count_right (count_right),
        .err         (err)
    );

    always #5 clk = ~clk;

    logic [W-1:0] q_l[$];
    logic [W-1:0] q_r[$];
    bit           pel;
    bit           per;
    logic [W-1:0] pdin;
    logic [2:0]   m_err;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout_l"}, 32'(dout_left),
              q_l.size() > 0 ? 32'(q_l[0]) : 32'd0);
        check({tag, ".dout_r"}, 32'(dout_right),
              q_r.size() > 0 ? 32'(q_r[0]) : 32'd0);
        check({tag, ".valid_l"}, 32'(valid_left), 32'(q_l.size() > 0));
        check({tag, ".valid_r"}, 32'(valid_right), 32'(q_r.size() > 0));
        check({tag, ".full_l"}, 32'(full_left), 32'(q_l.size() == D));
        check({tag, ".full_r"}, 32'(full_right), 32'(q_r.size() == D));
        check({tag, ".cnt_l"}, 32'(count_left), 32'(q_l.size()));
        check({tag, ".cnt_r"}, 32'(count_right), 32'(q_r.size()));
        check({tag, ".err"}, 32'(err), 32'(m_err));
    endtask

    task automatic model_reset();
        q_l.delete();
        q_r.delete();
        pel   = 1'b0;
        per   = 1'b0;
        pdin  = '0;
        m_err = '0;
    endtask

    task automatic step_l(input bit push, input bit pop, output bit ovf);
        ovf = 1'b0;
        if (pop && q_l.size() > 0) void'(q_l.pop_front());
        if (push) begin
            if (q_l.size() < D) q_l.push_back(Din);
            else begin
                ovf = 1'b1;
`ifdef STORE_OVERWRITE_EN
                void'(q_l.pop_front());
                q_l.push_back(Din);
`endif
            end
        end
    endtask

    task automatic step_r(input bit push, input bit pop, output bit ovf);
        ovf = 1'b0;
        if (pop && q_r.size() > 0) void'(q_r.pop_front());
        if (push) begin
            if (q_r.size() < D) q_r.push_back(Din);
            else begin
                ovf = 1'b1;
`ifdef STORE_OVERWRITE_EN
                void'(q_r.pop_front());
                q_r.push_back(Din);
`endif
            end
        end
    endtask

    task automatic model_step();
        bit c, wl, wr, ol, orr;
        c  = en_left && en_right;
        wl = en_left && !c && (!pel || Din != pdin);
        wr = en_right && !c && (!per || Din != pdin);
        step_l(wl, rd_left, ol);
        step_r(wr, rd_right, orr);
        m_err = clr_err ? {c, orr, ol} : (m_err | {c, orr, ol});
        pel  = en_left;
        per  = en_right;
        pdin = Din;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Held enable with steady data writes once.
        Din = 4'h2;
        en_left = 1'b1;
        for (int i = 0; i < 5; i++) tick("hold");
        check("hold.one_write", 32'(count_left), 32'd1);
        check("hold.dout", 32'(dout_left), 32'h2);
        en_left = 1'b0;
        rd_left = 1'b1;
        tick("drain0");
        rd_left = 1'b0;

        // Changing data under a held enable writes every cycle.
        en_right = 1'b1;
        Din = 4'h1; tick("step1");
        Din = 4'h3; tick("step3");
        Din = 4'h5; tick("step5");
        check("step.cnt3", 32'(count_right), 32'd3);
        en_right = 1'b0;
        rd_right = 1'b1;
        for (int i = 0; i < 3; i++) tick("rpop");
        rd_right = 1'b0;

        // Overflow of the left bank.
        en_left = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Din = 4'(2 * i);
            tick("fill");
        end
        check("ovf.err0", 32'(err[0]), 32'd1);
        en_left = 1'b0;
        rd_left = 1'b1;
        for (int i = 0; i < 4; i++) tick("opop");
        rd_left = 1'b0;
        clr_err = 1'b1;
        tick("clr1");
        clr_err = 1'b0;

        // Pop and write on a full bank.
        en_left = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Din = 4'(2 * i);
            tick("fill2");
        end
        rd_left = 1'b1;
        Din = 4'hA;
        tick("popwr");
        check("popwr.cnt", 32'(count_left), 32'd4);
        check("popwr.err0", 32'(err[0]), 32'd0);
        en_left = 1'b0;
        for (int i = 0; i < 4; i++) tick("fpop");
        rd_left = 1'b0;

        // Both enables high writes nothing.
        Din = 4'h4;
        en_left = 1'b1;
        en_right = 1'b1;
        tick("conf");
        check("conf.err", 32'(err), 32'h4);
        en_left = 1'b0;
        en_right = 1'b0;
        clr_err = 1'b1;
        tick("clr2");
        clr_err = 1'b0;
        check("clr2.err", 32'(err), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            en_left  = ($urandom_range(0, 9) < 5);
            en_right = en_left ? ($urandom_range(0, 9) == 0)
                               : ($urandom_range(0, 9) < 5);
            if ($urandom_range(0, 2) == 0) Din = W'($urandom);
            rd_left  = ($urandom_range(0, 9) < 3);
            rd_right = ($urandom_range(0, 9) < 3);
            clr_err  = ($urandom_range(0, 19) == 0);
            tick("rand");
        end
        en_left = 1'b0; en_right = 1'b0;
        rd_left = 1'b0; rd_right = 1'b0; clr_err = 1'b0;
        tick("quiet");

        // Asynchronous reset with entries stored.
        rd_left = 1'b1;
        for (int i = 0; i < 4; i++) tick("rdrain");
        rd_left = 1'b0;
        en_left = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Din = 4'(4 + 2 * i);
            tick("pre_rst");
        end
        check("pre_rst.cnt", 32'(count_left), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        Din = 4'h6;
        reset = 1'b1;
        tick("rst_rise");
        check("rst_rise.cnt", 32'(count_left), 32'd1);

        for (int i = 0; i < 200; i++) begin
            en_left  = ($urandom_range(0, 9) < 5);
            en_right = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 1) == 0) Din = W'($urandom);
            rd_left  = ($urandom_range(0, 9) < 4);
            rd_right = ($urandom_range(0, 9) < 4);
            clr_err  = ($urandom_range(0, 9) == 0);
            tick("rand2");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
